// File: rtl/cmndf_pkg.sv
// Shared types and default configuration for the CMNDF (YIN cumulative-mean-
// normalized difference) engine.
package cmndf_pkg;

  localparam int CMNDF_ACC_WIDTH = 39;
  localparam int CMNDF_MAX_TAU   = 40;
  localparam int CMNDF_FRAC_BITS = 10;
  localparam int CMNDF_OUT_WIDTH = 16;
  localparam int CMNDF_MIN_TAU   = 2;

  // Derived widths for the default configuration.
  localparam int TAU_BITS = $clog2(CMNDF_MAX_TAU);
  localparam int SUM_W    = CMNDF_ACC_WIDTH + TAU_BITS;
  localparam int DIV_W    = SUM_W + CMNDF_FRAC_BITS;
  localparam int ONE_Q    = 1 << CMNDF_FRAC_BITS;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_D,
    DIVIDE,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/cmndf_if.sv
// Stream interface of the CMNDF engine: d(tau) input handshake, d'(tau)
// output strobe and frame-level detection results.
interface cmndf_if
  import cmndf_pkg::*;
#(
  parameter int ACC_W = CMNDF_ACC_WIDTH,
  parameter int OUT_W = CMNDF_OUT_WIDTH,
  parameter int TAU_W = TAU_BITS
) ();

  logic [OUT_W-1:0] threshold;
  logic             start;
  logic             d_valid;
  logic [ACC_W-1:0] d_in;
  logic             d_ready;
  logic             cmndf_valid;
  logic [OUT_W-1:0] cmndf_out;
  logic [TAU_W-1:0] cmndf_tau;
  logic             done;
  logic             tau_found;
  logic [TAU_W-1:0] tau_est;

  // Producer/consumer side (drives frames in, takes results out).
  modport master (
    output threshold, start, d_valid, d_in,
    input  d_ready, cmndf_valid, cmndf_out, cmndf_tau, done, tau_found, tau_est
  );

  // The engine itself.
  modport slave (
    input  threshold, start, d_valid, d_in,
    output d_ready, cmndf_valid, cmndf_out, cmndf_tau, done, tau_found, tau_est
  );

endinterface

// File: rtl/cmndf_divider.sv
// Fixed-latency restoring divider: one quotient bit per cycle, N_W cycles per
// divide. A zero divisor is flagged and the iterations are skipped, but the
// counter still runs so timing never depends on data.
module cmndf_divider #(
  parameter int N_W = 55,
  parameter int D_W = 45
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] quotient,
  output logic           div_zero
);

  localparam int CNT_W = $clog2(N_W + 1);

  logic [N_W-1:0]   q;
  logic [D_W-1:0]   dsr;
  logic [D_W-1:0]   rem;
  logic [CNT_W-1:0] cnt;
  logic             zero;
  logic [D_W:0]     rem_sh;
  logic [D_W-1:0]   rem_sub;
  logic             take;

  // Trial subtraction of the shifted partial remainder.
  always_comb begin
    rem_sh  = {rem, q[N_W-1]};
    take    = rem_sh >= {1'b0, dsr};
    // The true difference is below the divisor whenever it is taken, so the
    // low D_W bits are exact.
    rem_sub = rem_sh[D_W-1:0] - dsr;
  end

  // Iteration register: load on start, then shift one quotient bit per cycle.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register here is a handful of flops, not a memory,
    // so all of them are reset; no array is left to power up as X.
    if (!reset) begin
      q    <= '0;
      dsr  <= '0;
      rem  <= '0;
      cnt  <= '0;
      zero <= 1'b0;
    end else if (start) begin
      // NOTE: non-blocking assignments make every register here update from
      // the pre-edge values, which is what a clocked divider step requires.
      q    <= dividend;
      dsr  <= divisor;
      rem  <= '0;
      cnt  <= CNT_W'(N_W);
      zero <= (divisor == '0);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (!zero) begin
        rem <= take ? rem_sub : rem_sh[D_W-1:0];
        q   <= {q[N_W-2:0], take};
      end
    end
  end

  assign busy     = (cnt != '0);
  // High during the cycle whose closing edge completes the last iteration.
  assign done     = (cnt == CNT_W'(1));
  assign quotient = q;
  assign div_zero = zero;

endmodule

// File: rtl/cmndf_module.sv
// Streaming CMNDF engine: d'(tau) = d(tau)*tau / sum_{j=1..tau} d(j) in
// unsigned Q.FRAC_BITS, plus the YIN absolute-threshold period search.
// Optional build macro: CMNDF_GLOBAL_MIN_FALLBACK_EN -- when no threshold
// crossing occurs, report the tau of the global minimum of d' instead of 0.
module cmndf_module
  import cmndf_pkg::*;
#(
  parameter int ACC_WIDTH = CMNDF_ACC_WIDTH,
  parameter int MAX_TAU   = CMNDF_MAX_TAU,
  parameter int FRAC_BITS = CMNDF_FRAC_BITS,
  parameter int OUT_WIDTH = CMNDF_OUT_WIDTH,
  parameter int MIN_TAU   = CMNDF_MIN_TAU
) (
  input logic   clk,
  input logic   reset,
  cmndf_if.slave bus
);

  localparam int TAU_W     = $clog2(MAX_TAU);
  localparam int SUM_WIDTH = ACC_WIDTH + TAU_W;
  localparam int DIV_WIDTH = SUM_WIDTH + FRAC_BITS;
  localparam logic [OUT_WIDTH-1:0] ONE_VAL = OUT_WIDTH'(1) << FRAC_BITS;

  state_t               state, state_nxt;
  logic [TAU_W-1:0]     tau;
  logic [SUM_WIDTH-1:0] sum, sum_add, den, prod;
  logic [DIV_WIDTH-1:0] num, quot;
  logic [OUT_WIDTH-1:0] thr, cur_val, cand_val;
  logic [TAU_W-1:0]     cand_tau, tau_est_q;
  logic                 found, tracking, tau_found_q;
  logic                 frame_start, xfer, last_tau, eligible;
  logic                 div_start, div_busy, div_done, div_zero;

`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
  logic [OUT_WIDTH-1:0] gmin_val;
  logic [TAU_W-1:0]     gmin_tau;
  logic                 gmin_valid;
`endif

  // start is honoured in IDLE and, as an abort, in WAIT_D; abort beats a
  // simultaneous transfer.
  assign frame_start = bus.start && (state == IDLE || state == WAIT_D);
  assign xfer        = (state == WAIT_D) && bus.d_valid && !bus.start;
  assign last_tau    = (tau == TAU_W'(MAX_TAU - 1));
  assign eligible    = (int'(tau) >= MIN_TAU);
  assign sum_add     = sum + SUM_WIDTH'(bus.d_in);
  assign prod        = SUM_WIDTH'(bus.d_in) * SUM_WIDTH'(tau);
  // Launch one divide on the first DIVIDE cycle; this extra cycle sits
  // between the operand latch and the first iteration.
  assign div_start   = (state == DIVIDE) && !div_busy;

  cmndf_divider #(
    .N_W (DIV_WIDTH),
    .D_W (SUM_WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (num),
    .divisor  (den),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quot),
    .div_zero (div_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning the default first means every path drives state_nxt,
    // so no latch is inferred for cases that do not change state.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = WAIT_D;
      WAIT_D: begin
        if (bus.start)        state_nxt = WAIT_D;
        else if (bus.d_valid) state_nxt = (tau == '0) ? EMIT : DIVIDE;
      end
      DIVIDE:  if (div_done) state_nxt = EMIT;
      EMIT:    state_nxt = last_tau ? DONE : WAIT_D;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current d': 1.0 for tau 0 and for a zero running sum, else the
  // saturated floor quotient.
  always_comb begin
    cur_val = quot[OUT_WIDTH-1:0];
    if (tau == '0 || div_zero)           cur_val = ONE_VAL;
    else if (|quot[DIV_WIDTH-1:OUT_WIDTH]) cur_val = '1;
  end

  // Frame datapath: running sum, divide operands, tau counter, search state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      thr         <= '0;
      sum         <= '0;
      den         <= '0;
      num         <= '0;
      tau         <= '0;
      found       <= 1'b0;
      tracking    <= 1'b0;
      cand_tau    <= '0;
      cand_val    <= '0;
      tau_found_q <= 1'b0;
      tau_est_q   <= '0;
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
      gmin_val    <= '0;
      gmin_tau    <= '0;
      gmin_valid  <= 1'b0;
`endif
    end else if (frame_start) begin
      thr         <= bus.threshold;
      sum         <= '0;
      tau         <= '0;
      found       <= 1'b0;
      tracking    <= 1'b0;
      cand_tau    <= '0;
      cand_val    <= '0;
      tau_found_q <= 1'b0;
      tau_est_q   <= '0;
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
      gmin_val    <= '0;
      gmin_tau    <= '0;
      gmin_valid  <= 1'b0;
`endif
    end else begin
      // d(0) is discarded; later samples feed the sum and the divider.
      if (xfer && tau != '0) begin
        sum <= sum_add;
        den <= sum_add;
        num <= {prod, {FRAC_BITS{1'b0}}};
      end

      if (state == EMIT) begin
        tau <= last_tau ? '0 : tau + TAU_W'(1);
        if (eligible) begin
          // First dip below threshold, then follow the strictly falling run
          // down to its local minimum; ties keep the earlier tau.
          if (!found) begin
            if (cur_val < thr) begin
              found    <= 1'b1;
              tracking <= 1'b1;
              cand_tau <= tau;
              cand_val <= cur_val;
            end
          end else if (tracking) begin
            if (cur_val < cand_val) begin
              cand_tau <= tau;
              cand_val <= cur_val;
            end else begin
              tracking <= 1'b0;
            end
          end
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
          if (!gmin_valid || cur_val < gmin_val) begin
            gmin_valid <= 1'b1;
            gmin_val   <= cur_val;
            gmin_tau   <= tau;
          end
`endif
        end
      end

      if (state == DONE) begin
        tau_found_q <= found;
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
        tau_est_q   <= found ? cand_tau : gmin_tau;
`else
        tau_est_q   <= found ? cand_tau : '0;
`endif
      end
    end
  end

  assign bus.d_ready     = (state == WAIT_D);
  assign bus.cmndf_valid = (state == EMIT);
  assign bus.cmndf_out   = (state == EMIT) ? cur_val : '0;
  assign bus.cmndf_tau   = (state == EMIT) ? tau : '0;
  assign bus.done        = (state == DONE);
  assign bus.tau_found   = tau_found_q;
  assign bus.tau_est     = tau_est_q;

endmodule

// File: tb/tb_cmndf_module.sv
// Self-checking bench for cmndf_module: scoreboard of expected d'(tau) values
// and emit cycles, plus frame-level detection checks.
module tb_cmndf_module;
  import cmndf_pkg::*;

  localparam int MAXT = CMNDF_MAX_TAU;
  localparam int MINT = CMNDF_MIN_TAU;

  typedef struct {
    int         tau;
    logic [63:0] val;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmndf_if #(.ACC_W(CMNDF_ACC_WIDTH), .OUT_W(CMNDF_OUT_WIDTH), .TAU_W(TAU_BITS)) bus ();

  cmndf_module dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_valid_cyc = 0;
  int          m_tau;
  logic [63:0] m_sum;
  logic [15:0] m_thr;
  logic [15:0] dp  [MAXT];
  logic [15:0] got [MAXT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model_dp(int t, logic [63:0] d, logic [63:0] s);
    logic [63:0] q;
    if (t == 0 || s == 0) return 64'(ONE_Q);
    q = (d * 64'(t) * 64'(ONE_Q)) / s;
    if (q > 64'hFFFF) q = 64'hFFFF;
    return q;
  endfunction

  function automatic logic [63:0] gen_d(int kind, int t);
    case (kind)
      0: case (t)
           0: return 64'd0;
           1: return 64'd100;
           2: return 64'd300;
           3: return 64'd20;
           4: return 64'd40;
           default: return 64'd100;
         endcase
      1: return 64'd100;
      default: return 64'd0;
    endcase
  endfunction

  // Expected detection result, found by scanning the whole d' frame.
  task automatic model_search(output logic f, output int est);
    int k;
    f   = 1'b0;
    est = 0;
    for (int t = MINT; t < MAXT; t++) begin
      if (!f && dp[t] < m_thr) begin
        f = 1'b1;
        k = t;
        while (k + 1 < MAXT && dp[k+1] < dp[k]) k++;
        est = k;
      end
    end
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
    if (!f) begin
      est = MINT;
      for (int t = MINT + 1; t < MAXT; t++) if (dp[t] < dp[est]) est = t;
    end
`endif
  endtask

  // Output monitor: pops the scoreboard on each cmndf_valid.
  always @(negedge clk) begin
    exp_t e;
    if (bus.cmndf_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(bus.cmndf_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("cmndf_out", 64'(bus.cmndf_out), e.val);
        check("cmndf_tau", 64'(bus.cmndf_tau), 64'(e.tau));
        check("emit_latency", 64'(cyc), 64'(e.cyc));
        check("ready_in_emit", 64'(bus.d_ready), 64'd0);
        got[e.tau] = bus.cmndf_out;
        last_valid_cyc = cyc;
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_frame(logic [15:0] thr);
    @(posedge clk); #1;
    bus.threshold = thr;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m_sum    = '0;
    m_tau    = 0;
    m_thr    = thr;
    done_cnt = 0;
    sb.delete();
    for (int t = 0; t < MAXT; t++) got[t] = '1;
  endtask

  task automatic drive(logic [63:0] d, int gap);
    int          w;
    logic [63:0] v;
    repeat (gap) @(posedge clk);
    #1;
    bus.d_valid = 1'b1;
    bus.d_in    = d[CMNDF_ACC_WIDTH-1:0];
    w = 0;
    @(negedge clk);
    while (!bus.d_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!bus.d_ready) begin
      check("ready_timeout", 64'(bus.d_ready), 64'd1);
      bus.d_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.d_valid = 1'b0;
    if (m_tau > 0) m_sum = m_sum + d;
    v = model_dp(m_tau, d, m_sum);
    dp[m_tau] = v[15:0];
    sb.push_back('{m_tau, v, (m_tau == 0) ? cyc : cyc + DIV_W + 1});
    m_tau++;
    @(negedge clk);
    check("ready_low_after_xfer", 64'(bus.d_ready), 64'd0);
  endtask

  task automatic wait_sb_empty();
    int w = 0;
    while (sb.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic finish_frame();
    int   w = 0;
    logic f;
    int   est;
    while (done_cnt == 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("done_after_last", 64'(done_cyc), 64'(last_valid_cyc + 1));
    check("sb_empty", 64'(sb.size()), 64'd0);
    model_search(f, est);
    check("tau_found", 64'(bus.tau_found), 64'(f));
    check("tau_est", 64'(bus.tau_est), 64'(est));
  endtask

  task automatic run_frame(logic [15:0] thr, int kind, int gap);
    start_frame(thr);
    for (int t = 0; t < MAXT; t++) drive(gen_d(kind, t), gap);
    finish_frame();
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_ready"}, 64'(bus.d_ready), 64'd0);
    check({tag, "_valid"}, 64'(bus.cmndf_valid), 64'd0);
    check({tag, "_out"}, 64'(bus.cmndf_out), 64'd0);
    check({tag, "_tau"}, 64'(bus.cmndf_tau), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_found"}, 64'(bus.tau_found), 64'd0);
    check({tag, "_est"}, 64'(bus.tau_est), 64'd0);
  endtask

  task automatic check_test1_values();
    check("t1_d0", 64'(got[0]), 64'd1024);
    check("t1_d1", 64'(got[1]), 64'd1024);
    check("t1_d2", 64'(got[2]), 64'd1536);
    check("t1_d3", 64'(got[3]), 64'd146);
    check("t1_d4", 64'(got[4]), 64'd356);
    check("t1_found", 64'(bus.tau_found), 64'd1);
    check("t1_est", 64'(bus.tau_est), 64'd3);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.threshold = '0;
    bus.start     = 1'b0;
    bus.d_valid   = 1'b0;
    bus.d_in      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // Reference frame with a clear dip at tau 3.
    run_frame(16'd154, 0, 0);
    check_test1_values();

    // Flat frame: d' stays at 1.0, never below 0.5.
    run_frame(16'd512, 1, 0);
    for (int t = 0; t < MAXT; t++) check("const_val", 64'(got[t]), 64'd1024);
    check("const_found", 64'(bus.tau_found), 64'd0);
    check("const_est", 64'(bus.tau_est), 64'd0);

    // All-zero frame: every divide hits the zero-sum bypass.
    run_frame(16'd154, 2, 0);
    for (int t = 0; t < MAXT; t++) check("zero_val", 64'(got[t]), 64'd1024);
    check("zero_found", 64'(bus.tau_found), 64'd0);
`ifdef CMNDF_GLOBAL_MIN_FALLBACK_EN
    check("zero_est", 64'(bus.tau_est), 64'd2);
`else
    check("zero_est", 64'(bus.tau_est), 64'd0);
`endif

    // Sparse input: five idle cycles before each sample.
    run_frame(16'd154, 0, 5);
    check_test1_values();

    // Abort in WAIT_D at tau 7, then a full frame must match the reference.
    start_frame(16'd154);
    for (int t = 0; t < 7; t++) drive(gen_d(1, t), 0);
    wait_sb_empty();
    @(negedge clk);
    check("abort_in_wait", 64'(bus.d_ready), 64'd1);
    run_frame(16'd154, 0, 0);
    check_test1_values();

    // Reset while dividing tau 10, then a clean frame.
    start_frame(16'd154);
    for (int t = 0; t <= 10; t++) drive(gen_d(0, t), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_no_done", 64'(done_cnt), 64'd0);
    run_frame(16'd154, 0, 0);
    check_test1_values();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmndf_module.md
Name: cmndf_module

Overview:
- Streaming cumulative-mean-normalized difference engine for the YIN pitch path.
- Consumes one frame of difference values d(tau), tau = 0..MAX_TAU-1, in order, with a valid/ready handshake. Typically these come from a bank of diff_module instances.
- Emits d'(tau) = d(tau)*tau / sum_{j=1..tau} d(j) as unsigned fixed point, with d'(0) = 1.0.
- Concurrently runs the absolute-threshold search and reports the pitch-period estimate at frame end.

Parameters:
- ACC_WIDTH, 39, width of incoming d(tau).
- MAX_TAU, 40, taus per frame (>= 2).
- FRAC_BITS, 10, fractional bits of d'.
- OUT_WIDTH, 16, width of d' output (unsigned Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS).
- MIN_TAU, 2, smallest tau eligible for detection (1..MAX_TAU-1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- threshold  in  OUT_WIDTH  detection threshold, same format as d'; sampled at start.
- start  in  1  one-cycle pulse that begins a frame.
- d_valid  in  1  d_in is valid.
- d_in  in  ACC_WIDTH  d(tau) for the current tau.
- d_ready  out  1  block accepts d_in this cycle.
- cmndf_valid  out  1  one-cycle pulse; cmndf_out/cmndf_tau are valid.
- cmndf_out  out  OUT_WIDTH  d'(tau).
- cmndf_tau  out  TAU_BITS  tau of cmndf_out; TAU_BITS = $clog2(MAX_TAU).
- done  out  1  one-cycle pulse at frame end.
- tau_found  out  1  threshold crossing found (held until next start).
- tau_est  out  TAU_BITS  estimated period (held until next start).

Behaviour:
- Reset values: all outputs 0. FSM = IDLE, running sum = 0, tau counter = 0.
- FSM states and transitions:
  - IDLE: start → WAIT_D; latch threshold; clear sum, tau, tau_found, tau_est, and search state.
  - WAIT_D: d_ready = 1; transfer when d_valid & d_ready.
    - tau == 0: d(0) is discarded; go to EMIT with d' = 1<<FRAC_BITS.
    - tau > 0: sum += d_in; latch numerator (d_in*tau) << FRAC_BITS and denominator = new sum; → DIVIDE.
  - DIVIDE: sequential restoring divide, one quotient bit per cycle, DIV_W = ACC_WIDTH+TAU_BITS+FRAC_BITS cycles; → EMIT.
  - EMIT: cmndf_valid pulses for exactly one cycle; search update; tau+1.
    - If tau was MAX_TAU-1 → DONE; else → WAIT_D.
  - DONE: done pulses for one cycle; → IDLE.
- Latency: d_in accepted at cycle N with tau > 0 → cmndf_valid at cycle N+DIV_W+2. For tau == 0 → N+1.
- Output has no backpressure; the consumer must take cmndf_valid when it pulses.
- Widths:
  - Sum is ACC_WIDTH+TAU_BITS bits and cannot overflow.
  - Quotient is truncated (floor).
  - Quotient > 2^OUT_WIDTH-1 saturates to all ones.
- Divide by zero (sum == 0): d' = 1<<FRAC_BITS; the divider is bypassed and still takes DIV_W cycles for fixed timing.
- Search runs only for tau >= MIN_TAU:
  - Not yet found, d' < threshold: candidate = tau, found = 1, tracking = 1.
  - Tracking and d' < candidate value: candidate = tau.
  - Tracking and d' >= candidate value: tracking stops; candidate is frozen.
  - Equal values keep the earlier tau.
  - At DONE: tau_found = found; tau_est = candidate (0 if not found; see Optional Feature).
- start outside IDLE: ignored, except in WAIT_D, where it aborts and restarts the frame with the same clearing as from IDLE.
- reset==0 mid-frame: immediate return to reset state; no done pulse.

Optional Feature:
- Macro CMNDF_GLOBAL_MIN_FALLBACK_EN.
- Defined: also track the global minimum of d' over tau >= MIN_TAU (earliest tau on ties). If no threshold crossing occurs, tau_est = global-min tau and tau_found = 0.
- Undefined: tau_est = 0 when not found; no extra registers.

Decomposition:
- Shared package cmndf_pkg: state enum (IDLE, WAIT_D, DIVIDE, EMIT, DONE) and localparams TAU_BITS, SUM_W, DIV_W, ONE_Q = 1<<FRAC_BITS.
- One sub-module, cmndf_divider:
  - Parameterised width; start/busy/done handshake.
  - Fixed DIV_W-cycle restoring divide.
  - Zero-divisor flag.

Test Plan:
- Defaults (FRAC_BITS=10), threshold=154, d = 0,100,300,20,40,100×35:
  - cmndf_out 1024,1024,1536,146,356,...
  - tau_found=1, tau_est=3.
- Constant d(tau)=100 for tau >= 1, threshold=512: every cmndf_out = 1024; tau_found=0, tau_est=0.
- All d=0:
  - every cmndf_out = 1024; no X values; timing identical to a nonzero frame.
  - With CMNDF_GLOBAL_MIN_FALLBACK_EN: tau_est = 2, tau_found=0.
- Handshake/latency: d_valid deasserted 5 cycles between samples:
  - d_ready low during DIVIDE/EMIT.
  - cmndf_valid exactly DIV_W+2 cycles after each tau > 0 transfer.
  - done exactly once, the cycle after the tau=39 output.
- Abort: start pulsed in WAIT_D at tau=7 → tau restarts at 0 and the sum clears. A second frame with the first test's data gives the same outputs as the first test.
- reset=0 during DIVIDE at tau=10 → next cycle all outputs 0, FSM IDLE; a following full frame is correct.
